// File: rtl/alto_wb_shared_bus_pkg.sv
// Shared definitions for the Alto Wishbone shared bus and future bus bridges:
// bus FSM encodings and the default transfer timeout.
package alto_wb_shared_bus_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } bus_state_e;

  localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/alto_rr_arbiter.sv
// N-way round-robin picker: grants the first requester at or above ptr_i,
// wrapping to the lowest requester below it.
module alto_rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o
);

  logic found;

  // First pass covers [ptr, N-1]; the second picks the lowest index, i.e. the wrap.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req_i[i] && (IDX_W'(i) >= ptr_i)) begin
        found    = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = IDX_W'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req_i[i]) begin
        found    = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/alto_wb_shared_bus.sv
// Wishbone classic shared bus: N masters, M slaves, one transfer at a time, with
// round-robin ownership, base/mask decode and a per-transfer unanswered-strobe timeout.
module alto_wb_shared_bus
  import alto_wb_shared_bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 2,
  parameter int ADR_WIDTH   = 16,
  parameter int DAT_WIDTH   = 16,
  parameter logic [NUM_SLAVES*ADR_WIDTH-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADR_WIDTH-1:0] SLAVE_MASK = '0,
  parameter int TIMEOUT     = DEFAULT_TIMEOUT
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NUM_MASTERS*ADR_WIDTH-1:0]   m_adr_i,
  input  logic [NUM_MASTERS-1:0]             m_cyc_i,
  input  logic [NUM_MASTERS-1:0]             m_stb_i,
  input  logic [NUM_MASTERS-1:0]             m_we_i,
  input  logic [NUM_MASTERS*DAT_WIDTH/8-1:0] m_sel_i,
  input  logic [NUM_MASTERS*DAT_WIDTH-1:0]   m_dat_i,
  output logic [NUM_MASTERS*DAT_WIDTH-1:0]   m_dat_o,
  output logic [NUM_MASTERS-1:0]             m_ack_o,
  output logic [NUM_MASTERS-1:0]             m_err_o,
  output logic [ADR_WIDTH-1:0]               s_adr_o,
  output logic [DAT_WIDTH-1:0]               s_dat_o,
  output logic [DAT_WIDTH/8-1:0]             s_sel_o,
  output logic                               s_we_o,
  output logic [NUM_SLAVES-1:0]              s_cyc_o,
  output logic [NUM_SLAVES-1:0]              s_stb_o,
  input  logic [NUM_SLAVES*DAT_WIDTH-1:0]    s_dat_i,
  input  logic [NUM_SLAVES-1:0]              s_ack_i,
  input  logic [NUM_SLAVES-1:0]              s_err_i,
  output logic [NUM_MASTERS-1:0]             grant_o
);

  localparam int SEL_WIDTH = DAT_WIDTH / 8;
  localparam int IDX_W     = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SIDX_W    = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  bus_state_e             state_q, state_d;
  logic [IDX_W-1:0]       owner_q, owner_d, rr_ptr_q, rr_ptr_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   int_err_q, int_err_d;

  logic [NUM_MASTERS-1:0] arb_gnt;
  logic [IDX_W-1:0]       arb_idx;

  logic                   owned, own_cyc, own_stb, own_we;
  logic [ADR_WIDTH-1:0]   own_adr;
  logic [DAT_WIDTH-1:0]   own_dat;
  logic [SEL_WIDTH-1:0]   own_sel;

  logic                   hit, sel_ack, sel_err, answered;
  logic [SIDX_W-1:0]      slv_idx;
  logic [DAT_WIDTH-1:0]   sel_dat;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : idx + IDX_W'(1);
  endfunction

  alto_rr_arbiter #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_i (m_cyc_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  assign owned = (state_q == ST_OWNED);

  // Owner's request; all zero while idle so the broadcast outputs rest at zero.
  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_adr = '0;
    own_dat = '0;
    own_sel = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (owned && (owner_q == IDX_W'(i))) begin
        own_cyc = m_cyc_i[i];
        own_stb = m_cyc_i[i] & m_stb_i[i];
        own_we  = m_we_i[i];
        own_adr = m_adr_i[i*ADR_WIDTH +: ADR_WIDTH];
        own_dat = m_dat_i[i*DAT_WIDTH +: DAT_WIDTH];
        own_sel = m_sel_i[i*SEL_WIDTH +: SEL_WIDTH];
      end
    end
  end

  always_comb begin
    hit     = 1'b0;
    slv_idx = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (owned && !hit &&
          ((own_adr & SLAVE_MASK[k*ADR_WIDTH +: ADR_WIDTH]) == SLAVE_BASE[k*ADR_WIDTH +: ADR_WIDTH])) begin
        hit     = 1'b1;
        slv_idx = SIDX_W'(k);
      end
    end
  end

  always_comb begin
    s_cyc_o = '0;
    s_stb_o = '0;
    sel_ack = 1'b0;
    sel_err = 1'b0;
    sel_dat = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (hit && (slv_idx == SIDX_W'(k))) begin
        s_cyc_o[k] = own_cyc;
        s_stb_o[k] = own_stb;
        sel_ack    = s_ack_i[k];
        sel_err    = s_err_i[k];
        sel_dat    = s_dat_i[k*DAT_WIDTH +: DAT_WIDTH];
      end
    end
  end

  // Combinational return path keeps zero-wait-state slaves at single-cycle acks.
  always_comb begin
    m_ack_o = '0;
    m_err_o = '0;
    m_dat_o = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (owned && (owner_q == IDX_W'(i))) begin
        m_ack_o[i] = own_cyc & hit & sel_ack;
        m_err_o[i] = own_cyc & ((hit & sel_err) | int_err_q);
        if (hit) begin
          m_dat_o[i*DAT_WIDTH +: DAT_WIDTH] = sel_dat;
        end
      end
    end
  end

  assign s_adr_o = own_adr;
  assign s_dat_o = own_dat;
  assign s_sel_o = own_sel;
  assign s_we_o  = own_we;
  assign grant_o = grant_q;

  // An internal error counts as the answer, so int_err can never fire twice running.
  assign answered = (hit & (sel_ack | sel_err)) | int_err_q;

  always_comb begin
    cnt_d     = '0;
    int_err_d = 1'b0;
    if (own_stb && !answered) begin
      if (!hit) begin
        int_err_d = 1'b1;
      end else if (TIMEOUT != 0) begin
        if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          int_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    case (state_q)
      ST_IDLE: begin
        if (|m_cyc_i) begin
          state_d = ST_OWNED;
          owner_d = arb_idx;
          grant_d = arb_gnt;
        end
      end
      ST_OWNED: begin
        if (!own_cyc) begin
          state_d  = ST_IDLE;
          grant_d  = '0;
          rr_ptr_d = wrap_inc(owner_q);
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      cnt_q     <= '0;
      int_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      int_err_q <= int_err_d;
    end
  end

endmodule

// File: tb/tb_alto_wb_shared_bus.sv
// Directed bench for alto_wb_shared_bus: two masters, a read-only RAM at slave 0
// and a programmable-latency responder at slave 1.
module tb_alto_wb_shared_bus;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] m_adr;
  logic [1:0]  m_cyc, m_stb, m_we;
  logic [3:0]  m_sel;
  logic [31:0] m_dat;
  logic [31:0] m_dat_o;
  logic [1:0]  m_ack_o, m_err_o;
  logic [15:0] s_adr_o, s_dat_o;
  logic [1:0]  s_sel_o;
  logic        s_we_o;
  logic [1:0]  s_cyc_o, s_stb_o;
  logic [31:0] s_dat_i;
  logic [1:0]  s_ack_i, s_err_i;
  logic [1:0]  grant_o;

  logic        never_ack;
  logic [7:0]  resp_lat;
  logic [7:0]  resp_cnt;
  logic [15:0] resp_wdata;
  logic [1:0]  resp_wsel;
  logic [7:0]  ram_wr_cnt;
  logic [15:0] ram_rdata;
  logic        resp_ack;

  int n_checks = 0;
  int n_errors = 0;
  int n;

  always #5 clk = ~clk;

  alto_wb_shared_bus #(
    .NUM_MASTERS (2),
    .NUM_SLAVES  (2),
    .ADR_WIDTH   (16),
    .DAT_WIDTH   (16),
    .SLAVE_BASE  ({16'h8000, 16'h0000}),
    .SLAVE_MASK  ({16'hFF00, 16'h8000}),
    .TIMEOUT     (8)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .m_adr_i (m_adr),
    .m_cyc_i (m_cyc),
    .m_stb_i (m_stb),
    .m_we_i  (m_we),
    .m_sel_i (m_sel),
    .m_dat_i (m_dat),
    .m_dat_o (m_dat_o),
    .m_ack_o (m_ack_o),
    .m_err_o (m_err_o),
    .s_adr_o (s_adr_o),
    .s_dat_o (s_dat_o),
    .s_sel_o (s_sel_o),
    .s_we_o  (s_we_o),
    .s_cyc_o (s_cyc_o),
    .s_stb_o (s_stb_o),
    .s_dat_i (s_dat_i),
    .s_ack_i (s_ack_i),
    .s_err_i (s_err_i),
    .grant_o (grant_o)
  );

  // Slave 0: zero-wait RAM image with two preloaded words; writes are only counted.
  always_comb begin
    ram_rdata = 16'h0000;
    if (s_adr_o == 16'h0010) ram_rdata = 16'hBEEF;
    if (s_adr_o == 16'h0030) ram_rdata = 16'h5A5A;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) ram_wr_cnt <= 8'd0;
    else if (s_cyc_o[0] && s_stb_o[0] && s_we_o) ram_wr_cnt <= ram_wr_cnt + 8'd1;
  end

  // Slave 1: acks resp_lat cycles after strobe, or never when never_ack is set.
  assign resp_ack = s_cyc_o[1] && s_stb_o[1] && !never_ack && (resp_cnt == resp_lat);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_cnt   <= 8'd0;
      resp_wdata <= 16'h0000;
      resp_wsel  <= 2'b00;
    end else if (s_cyc_o[1] && s_stb_o[1]) begin
      if (resp_ack) begin
        resp_cnt <= 8'd0;
        if (s_we_o) begin
          resp_wdata <= s_dat_o;
          resp_wsel  <= s_sel_o;
        end
      end else begin
        resp_cnt <= resp_cnt + 8'd1;
      end
    end else begin
      resp_cnt <= 8'd0;
    end
  end

  assign s_dat_i = {16'hC0DE, ram_rdata};
  assign s_ack_i = {resp_ack, s_cyc_o[0] & s_stb_o[0]};
  assign s_err_i = 2'b00;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m(input int i, input logic cyc, input logic stb, input logic we,
                         input logic [15:0] adr, input logic [15:0] dat, input logic [1:0] sel);
    m_cyc[i]          = cyc;
    m_stb[i]          = stb;
    m_we[i]           = we;
    m_adr[i*16 +: 16] = adr;
    m_dat[i*16 +: 16] = dat;
    m_sel[i*2 +: 2]   = sel;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '0; m_adr = '0; m_dat = '0;
    never_ack = 1'b0;
    resp_lat  = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_eq("rst_grant", grant_o, 2'b00);
    chk_eq("rst_s_cyc", s_cyc_o, 2'b00);
    chk_eq("rst_s_stb", s_stb_o, 2'b00);
    chk_eq("rst_m_ack", m_ack_o, 2'b00);
    chk_eq("rst_m_err", m_err_o, 2'b00);
    chk_eq("rst_m_dat", m_dat_o, 32'h0);
    chk_eq("rst_s_adr", s_adr_o, 16'h0);
    rst = 1'b0;

    // 1: master0 reads 0x0010
    drive_m(0, 1, 1, 0, 16'h0010, 16'h0, 2'b11);
    #1 chk_eq("t1_arb_latency", grant_o, 2'b00);
    step();
    chk_eq("t1_grant", grant_o, 2'b01);
    chk_eq("t1_s_stb", s_stb_o, 2'b01);
    chk_eq("t1_s_adr", s_adr_o, 16'h0010);
    chk_eq("t1_ack", m_ack_o, 2'b01);
    chk_eq("t1_dat", m_dat_o, 32'h0000BEEF);
    step();
    drive_m(0, 0, 0, 0, 16'h0, 16'h0, 2'b00);
    step();
    chk_eq("t1_release", grant_o, 2'b00);

    // 2: contention straight after reset, then round-robin turn
    rst = 1'b1;
    #1 rst = 1'b0;
    drive_m(0, 1, 1, 0, 16'h0020, 16'h0, 2'b11);
    drive_m(1, 1, 1, 0, 16'h0030, 16'h0, 2'b11);
    step();
    chk_eq("t2_m0_first", grant_o, 2'b01);
    chk_eq("t2_ack_owner_only", m_ack_o, 2'b01);
    step();
    drive_m(0, 0, 0, 0, 16'h0, 16'h0, 2'b00);
    step();
    chk_eq("t2_idle_gap", grant_o, 2'b00);
    step();
    chk_eq("t2_m1_next", grant_o, 2'b10);
    chk_eq("t2_m1_dat", m_dat_o, 32'h5A5A0000);
    drive_m(1, 0, 0, 0, 16'h0, 16'h0, 2'b00);
    step();
    drive_m(0, 1, 1, 0, 16'h0010, 16'h0, 2'b11);
    step();
    chk_eq("t2_solo_m0", grant_o, 2'b01);
    drive_m(0, 0, 0, 0, 16'h0, 16'h0, 2'b00);
    step();
    drive_m(0, 1, 1, 0, 16'h0020, 16'h0, 2'b11);
    drive_m(1, 1, 1, 0, 16'h0030, 16'h0, 2'b11);
    step();
    chk_eq("t2_rr_m1_first", grant_o, 2'b10);
    drive_m(0, 0, 0, 0, 16'h0, 16'h0, 2'b00);
    drive_m(1, 0, 0, 0, 16'h0, 16'h0, 2'b00);
    step();

    // 3: master1 write to responder with latency 3
    resp_lat = 8'd3;
    drive_m(1, 1, 1, 1, 16'h8005, 16'h1234, 2'b01);
    step();
    chk_eq("t3_grant", grant_o, 2'b10);
    chk_eq("t3_s_stb", s_stb_o, 2'b10);
    chk_eq("t3_s_cyc", s_cyc_o, 2'b10);
    chk_eq("t3_s_adr", s_adr_o, 16'h8005);
    chk_eq("t3_s_dat", s_dat_o, 16'h1234);
    chk_eq("t3_s_sel", s_sel_o, 2'b01);
    chk_eq("t3_s_we", s_we_o, 1'b1);
    chk_eq("t3_no_early_ack", m_ack_o, 2'b00);
    n = 0;
    while (m_ack_o[1] !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    chk_eq("t3_ack_latency", n, 3);
    chk_eq("t3_no_err", m_err_o, 2'b00);
    step();
    drive_m(1, 0, 0, 0, 16'h0, 16'h0, 2'b00);
    step();
    chk_eq("t3_resp_wdata", resp_wdata, 16'h1234);
    chk_eq("t3_resp_wsel", resp_wsel, 2'b01);
    chk_eq("t3_ram_untouched", ram_wr_cnt, 8'd0);

    // 4: unmapped address
    drive_m(0, 1, 1, 0, 16'h9000, 16'h0, 2'b11);
    step();
    chk_eq("t4_no_slave_stb", s_stb_o, 2'b00);
    chk_eq("t4_no_slave_cyc", s_cyc_o, 2'b00);
    chk_eq("t4_err_not_yet", m_err_o, 2'b00);
    step();
    chk_eq("t4_err_pulse", m_err_o, 2'b01);
    chk_eq("t4_no_ack", m_ack_o, 2'b00);
    step();
    chk_eq("t4_err_single", m_err_o, 2'b00);
    drive_m(0, 0, 0, 0, 16'h0, 16'h0, 2'b00);
    step();

    // 5: responder never answers, timeout of 8
    never_ack = 1'b1;
    drive_m(1, 1, 1, 0, 16'h8010, 16'h0, 2'b11);
    step();
    chk_eq("t5_grant", grant_o, 2'b10);
    n = 0;
    while (m_err_o[1] !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk_eq("t5_timeout_cycles", n, 8);
    chk_eq("t5_stb_held", s_stb_o, 2'b10);
    step();
    chk_eq("t5_err_single", m_err_o, 2'b00);
    chk_eq("t5_stb_still_held", s_stb_o, 2'b10);
    drive_m(1, 0, 0, 0, 16'h0, 16'h0, 2'b00);
    step();
    chk_eq("t5_idle", grant_o, 2'b00);
    never_ack = 1'b0;
    drive_m(0, 1, 1, 0, 16'h0010, 16'h0, 2'b11);
    step();
    chk_eq("t5_next_grant", grant_o, 2'b01);
    chk_eq("t5_next_ack", m_ack_o, 2'b01);
    chk_eq("t5_next_dat", m_dat_o, 32'h0000BEEF);
    drive_m(0, 0, 0, 0, 16'h0, 16'h0, 2'b00);
    step();

    // 6: asynchronous reset mid-transfer
    never_ack = 1'b1;
    drive_m(1, 1, 1, 0, 16'h8020, 16'h0, 2'b11);
    step();
    chk_eq("t6_granted", grant_o, 2'b10);
    chk_eq("t6_stb_before", s_stb_o, 2'b10);
    #2 rst = 1'b1;
    #1;
    chk_eq("t6_rst_grant", grant_o, 2'b00);
    chk_eq("t6_rst_s_cyc", s_cyc_o, 2'b00);
    chk_eq("t6_rst_s_stb", s_stb_o, 2'b00);
    chk_eq("t6_rst_s_adr", s_adr_o, 16'h0);
    chk_eq("t6_rst_m_err", m_err_o, 2'b00);
    drive_m(1, 0, 0, 0, 16'h0, 16'h0, 2'b00);
    step();
    step();
    rst = 1'b0;
    never_ack = 1'b0;
    resp_lat = 8'd0;
    drive_m(1, 1, 1, 0, 16'h8020, 16'h0, 2'b11);
    step();
    chk_eq("t6_regrant", grant_o, 2'b10);
    chk_eq("t6_ack", m_ack_o, 2'b10);
    chk_eq("t6_dat", m_dat_o, 32'hC0DE0000);
    drive_m(1, 0, 0, 0, 16'h0, 16'h0, 2'b00);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
